// File: rtl/udma_ctrl_dp_out_arb_if.sv
// rtl/udma_ctrl_dp_out_arb_if.sv - channel/output stream bundle for the uDMA data-plane output arbiter
interface udma_ctrl_dp_out_arb_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32,
  parameter int CH_W   = $clog2(N_CH)
);
  logic                   mode_i;
  logic [N_CH-1:0]        ch_en_i;
  logic [N_CH-1:0]        ch_flush_i;
  logic [N_CH-1:0]        ch_valid_i;
  logic [N_CH-1:0]        ch_ready_o;
  logic [N_CH*DATA_W-1:0] ch_data_i;
  logic [N_CH*2-1:0]      ch_size_i;
  logic [N_CH-1:0]        ch_empty_o;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [DATA_W-1:0]      out_data_o;
  logic [1:0]             out_size_o;
  logic [CH_W-1:0]        out_ch_o;

  modport slave (
    input  mode_i, ch_en_i, ch_flush_i, ch_valid_i, ch_data_i, ch_size_i, out_ready_i,
    output ch_ready_o, ch_empty_o, out_valid_o, out_data_o, out_size_o, out_ch_o
  );

  modport master (
    output mode_i, ch_en_i, ch_flush_i, ch_valid_i, ch_data_i, ch_size_i, out_ready_i,
    input  ch_ready_o, ch_empty_o, out_valid_o, out_data_o, out_size_o, out_ch_o
  );
endinterface

// File: rtl/udma_ctrl_dp_out_arb.sv
// rtl/udma_ctrl_dp_out_arb.sv - per-channel FIFOs arbitrated (round-robin / fixed) onto one registered stream
module udma_ctrl_dp_out_arb #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CH_W   = $clog2(N_CH)
) (
  input  logic clk,
  input  logic reset_n,
  udma_ctrl_dp_out_arb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [CH_W:0] NCH_P   = (CH_W+1)'(N_CH);

  logic [DATA_W-1:0] fifo_data [N_CH][DEPTH];
  logic [1:0]        fifo_size [N_CH][DEPTH];
  logic [PW-1:0]     wr_ptr    [N_CH];
  logic [PW-1:0]     rd_ptr    [N_CH];

  logic [N_CH-1:0]   full, empty, push, pop, elig;
  logic [CH_W-1:0]   rr_ptr, grant;
  logic [CH_W:0]     idx;
  logic              grant_vld, load;
  logic [DATA_W-1:0] head_data, keep, masked;
  logic [1:0]        head_size;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [1:0]        out_size_q;
  logic [CH_W-1:0]   out_ch_q;

  // A flushing channel neither accepts a push nor competes for the grant this cycle.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      full[c]  = (wr_ptr[c] - rd_ptr[c]) == DEPTH_P;
      empty[c] = (wr_ptr[c] == rd_ptr[c]);
      elig[c]  = !empty[c] && bus.ch_en_i[c] && !bus.ch_flush_i[c];
      push[c]  = bus.ch_valid_i[c] && !full[c] && !bus.ch_flush_i[c];
    end
  end

  assign bus.ch_ready_o = ~full;
  assign bus.ch_empty_o = empty;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.mode_i) begin
        idx = (CH_W+1)'(i);
      end else begin
        idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
        if (idx >= NCH_P) idx = idx - NCH_P;
      end
      if (!grant_vld && elig[idx[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant     = idx[CH_W-1:0];
      end
    end
  end

  assign load = (!out_valid_q || bus.out_ready_i) && grant_vld;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      pop[c] = load && (grant == CH_W'(c));
    end
  end

  assign head_data = fifo_data[grant][rd_ptr[grant][AW-1:0]];
  assign head_size = fifo_size[grant][rd_ptr[grant][AW-1:0]];

  // Size 2 on a narrow bus and size 3 both fall through to the full width.
  always_comb begin
    for (int b = 0; b < DATA_W; b++) begin
      keep[b] = (head_size == 2'd3) || (head_size == 2'd2 && b < 32) ||
                (head_size == 2'd1 && b < 16) || (b < 8);
    end
    masked = head_data & keep;
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (push[c]) begin
        fifo_data[c][wr_ptr[c][AW-1:0]] <= bus.ch_data_i[c*DATA_W +: DATA_W];
        fifo_size[c][wr_ptr[c][AW-1:0]] <= bus.ch_size_i[c*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (bus.ch_flush_i[c]) begin
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
        end else begin
          if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
          if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        end
      end
    end
  end

  // rr_ptr only advances on round-robin grants so a fixed-priority spell leaves it intact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (load && !bus.mode_i) begin
      rr_ptr <= (grant == CH_W'(N_CH-1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_size_q  <= '0;
      out_ch_q    <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= masked;
      out_size_q  <= head_size;
      out_ch_q    <= grant;
    end else if (bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_size_o  = out_size_q;
  assign bus.out_ch_o    = out_ch_q;
endmodule

// File: tb/tb_udma_ctrl_dp_out_arb.sv
// tb/tb_udma_ctrl_dp_out_arb.sv - self-checking bench for udma_ctrl_dp_out_arb
module tb_udma_ctrl_dp_out_arb;
  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  udma_ctrl_dp_out_arb_if #(.N_CH(N), .DATA_W(W)) bus ();
  udma_ctrl_dp_out_arb #(.N_CH(N), .DATA_W(W), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct packed { logic [31:0] d; logic [1:0] s; } beat_t;
  typedef struct { logic [31:0] d; logic [1:0] s; logic [31:0] exp; } mask_vec_t;

  beat_t       q [N][$];
  bit          m_ov;
  logic [31:0] m_od;
  logic [1:0]  m_os;
  int          m_och;
  int          rr;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(logic [31:0] d, logic [1:0] s);
    case (s)
      2'd0:    return d & 32'h0000_00FF;
      2'd1:    return d & 32'h0000_FFFF;
      default: return d;
    endcase
  endfunction

  function automatic bit busy();
    bit b = m_ov;
    for (int c = 0; c < N; c++) if (q[c].size() != 0) b = 1;
    return b;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) q[c].delete();
    m_ov = 0; m_od = '0; m_os = '0; m_och = 0; rr = 0;
  endtask

  task automatic set_idle();
    bus.mode_i = 1'b0; bus.ch_en_i = '1; bus.ch_flush_i = '0; bus.ch_valid_i = '0;
    bus.ch_data_i = '0; bus.ch_size_i = '0; bus.out_ready_i = 1'b1;
  endtask

  task automatic drive(int c, logic [31:0] d, logic [1:0] s);
    bus.ch_valid_i[c] = 1'b1;
    bus.ch_data_i[c*W +: W] = d;
    bus.ch_size_i[c*2 +: 2] = s;
  endtask

  // Called just after a falling edge with inputs applied; returns just after the next falling edge.
  task automatic tick();
    bit    rdy [N];
    int    g, c;
    beat_t nb;
    #1;
    for (int k = 0; k < N; k++) begin
      rdy[k] = q[k].size() < D;
      chk("ch_ready", 32'(bus.ch_ready_o[k]), 32'(rdy[k]));
      chk("ch_empty", 32'(bus.ch_empty_o[k]), 32'(q[k].size() == 0));
    end
    g = -1;
    for (int k = 0; k < N; k++) begin
      c = bus.mode_i ? k : (rr + k) % N;
      if (g < 0 && q[c].size() > 0 && bus.ch_en_i[c] && !bus.ch_flush_i[c]) g = c;
    end
    if ((!m_ov || bus.out_ready_i) && g >= 0) begin
      nb = q[g].pop_front();
      m_ov = 1; m_od = mask_of(nb.d, nb.s); m_os = nb.s; m_och = g;
      if (!bus.mode_i) rr = (g + 1) % N;
    end else if (bus.out_ready_i) begin
      m_ov = 0;
    end
    for (int k = 0; k < N; k++) begin
      if (bus.ch_flush_i[k]) q[k].delete();
      else if (bus.ch_valid_i[k] && rdy[k]) begin
        nb.d = bus.ch_data_i[k*W +: W];
        nb.s = bus.ch_size_i[k*2 +: 2];
        q[k].push_back(nb);
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid_o), 32'(m_ov));
    if (m_ov) begin
      chk("out_data", bus.out_data_o, m_od);
      chk("out_size", 32'(bus.out_size_o), 32'(m_os));
      chk("out_ch", 32'(bus.out_ch_o), 32'(m_och));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    set_idle();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain();
    bus.ch_valid_i = '0; bus.ch_flush_i = '0; bus.ch_en_i = '1; bus.out_ready_i = 1'b1;
    for (int i = 0; i < 40 && busy(); i++) tick();
    chk("drain_done", 32'(busy()), 32'd0);
  endtask

  mask_vec_t mv [6];

  initial begin
    mv[0] = '{d: 32'hDEADBEEF, s: 2'd0, exp: 32'h000000EF};
    mv[1] = '{d: 32'hDEADBEEF, s: 2'd1, exp: 32'h0000BEEF};
    mv[2] = '{d: 32'hDEADBEEF, s: 2'd2, exp: 32'hDEADBEEF};
    mv[3] = '{d: 32'hDEADBEEF, s: 2'd3, exp: 32'hDEADBEEF};
    mv[4] = '{d: 32'h12345678, s: 2'd0, exp: 32'h00000078};
    mv[5] = '{d: 32'hCAFE8001, s: 2'd1, exp: 32'h00008001};

    reset_n = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_out_data", bus.out_data_o, 32'd0);
    chk("rst_out_size", 32'(bus.out_size_o), 32'd0);
    chk("rst_out_ch", 32'(bus.out_ch_o), 32'd0);
    chk("rst_ch_empty", 32'(bus.ch_empty_o), 32'hF);
    chk("rst_ch_ready", 32'(bus.ch_ready_o), 32'hF);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic latency: pushed at edge E, visible after E+1
    drive(1, 32'hA5A5A5A5, 2'd2);
    tick();
    chk("basic_no_bypass", 32'(bus.out_valid_o), 32'd0);
    bus.ch_valid_i = '0;
    tick();
    chk("basic_valid", 32'(bus.out_valid_o), 32'd1);
    chk("basic_ch", 32'(bus.out_ch_o), 32'd1);
    chk("basic_data", bus.out_data_o, 32'hA5A5A5A5);
    tick();
    chk("basic_done", 32'(bus.out_valid_o), 32'd0);
    chk("basic_empty", 32'(bus.ch_empty_o), 32'hF);

    // Round-robin fairness
    do_reset();
    bus.out_ready_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < N; c++) drive(c, 32'(c * 16 + b), 2'd3);
      tick();
    end
    bus.ch_valid_i = '0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("rr_valid", 32'(bus.out_valid_o), 32'd1);
      chk("rr_seq", 32'(bus.out_ch_o), 32'(i % 4));
      tick();
    end
    drain();

    // Fixed priority with ch0 disabled
    do_reset();
    bus.mode_i = 1'b1;
    bus.ch_en_i = 4'b1110;
    bus.out_ready_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive(0, 32'h100 + 32'(b), 2'd2);
      drive(2, 32'h200 + 32'(b), 2'd2);
      tick();
    end
    bus.ch_valid_i = '0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid_o) chk("fp_only_ch2", 32'(bus.out_ch_o), 32'd2);
      tick();
    end
    chk("fp_ch0_blocked", 32'(bus.out_valid_o), 32'd0);
    bus.ch_en_i = 4'b1111;
    tick();
    chk("fp_ch0_grant_v", 32'(bus.out_valid_o), 32'd1);
    chk("fp_ch0_grant", 32'(bus.out_ch_o), 32'd0);
    drain();

    // Backpressure and full FIFO on ch3
    do_reset();
    bus.out_ready_i = 1'b0;
    for (int b = 0; b < 6; b++) begin
      drive(3, 32'h3000 + 32'(b), 2'd2);
      tick();
      if (b == 4) chk("bp_full_ready", 32'(bus.ch_ready_o[3]), 32'd0);
      if (b >= 1) chk("bp_hold", bus.out_data_o, 32'h3000);
    end
    bus.ch_valid_i = '0;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_seq_v", 32'(bus.out_valid_o), 32'd1);
      chk("bp_seq_d", bus.out_data_o, 32'h3000 + 32'(k));
      tick();
    end
    chk("bp_no_extra", 32'(bus.out_valid_o), 32'd0);

    // Size masking vectors
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, mv[i].d, mv[i].s);
      tick();
      bus.ch_valid_i = '0;
      tick();
      chk("mask_data", bus.out_data_o, mv[i].exp);
      chk("mask_size", 32'(bus.out_size_o), 32'(mv[i].s));
      tick();
    end

    // Flush colliding with a push, beat already registered survives
    do_reset();
    bus.out_ready_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive(2, 32'h2200 + 32'(b), 2'd2);
      tick();
    end
    drive(2, 32'h22FF, 2'd2);
    bus.ch_flush_i[2] = 1'b1;
    tick();
    chk("fl_empty", 32'(bus.ch_empty_o[2]), 32'd1);
    chk("fl_keep_v", 32'(bus.out_valid_o), 32'd1);
    chk("fl_keep_d", bus.out_data_o, 32'h2200);
    bus.ch_flush_i = '0;
    bus.ch_valid_i = '0;
    bus.out_ready_i = 1'b1;
    tick();
    chk("fl_dropped", 32'(bus.out_valid_o), 32'd0);

    // Randomized traffic against the queue model, with one asynchronous reset midway
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        bus.ch_valid_i[c] = 1'($urandom_range(0, 1));
        bus.ch_data_i[c*W +: W] = $urandom;
        bus.ch_size_i[c*2 +: 2] = 2'($urandom_range(0, 3));
        bus.ch_en_i[c] = ($urandom_range(0, 3) != 0);
        bus.ch_flush_i[c] = ($urandom_range(0, 31) == 0);
      end
      if ($urandom_range(0, 15) == 0) bus.mode_i = ~bus.mode_i;
      bus.out_ready_i = ($urandom_range(0, 9) < 7);
      if (i == 1500) begin
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("async_rst_empty", 32'(bus.ch_empty_o), 32'hF);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
      end
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/udma_ctrl_dp_out_arb.md
# udma_ctrl_dp_out_arb

Parametrised multi-channel data-plane output stage for the uDMA controller. It buffers per-channel beats in independent FIFOs and arbitrates them onto a single registered valid/ready output stream. Arbitration is round-robin or fixed-priority, selectable at run time. Each channel supports per-beat transfer size, enable and flush. It sits between the uDMA channel engines and the peripheral/L2 write path, and generalises the single-channel data-plane output to N channels.

## Interface

Parameters:
- N_CH, 4, number of channels (2..16)
- DATA_W, 32, beat data width (multiple of 8, 8..64)
- DEPTH, 4, per-channel FIFO depth (power of 2, 2..16)
- CH_W, $clog2(N_CH), channel index width (derived)

Ports:
- clk  input  1  clock, all state rising-edge
- reset_n  input  1  asynchronous active-low reset
- mode_i  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- ch_en_i  input  N_CH  per-channel arbitration enable
- ch_flush_i  input  N_CH  per-channel FIFO flush, single-cycle pulse
- ch_valid_i  input  N_CH  per-channel beat valid
- ch_ready_o  output  N_CH  per-channel ready (= FIFO not full)
- ch_data_i  input  N_CH*DATA_W  channel c data at [c*DATA_W +: DATA_W]
- ch_size_i  input  N_CH*2  size: 0 byte, 1 half, 2 word, 3 = full DATA_W
- out_valid_o  output  1  output beat valid (registered)
- out_ready_i  input  1  output consumer ready
- out_data_o  output  DATA_W  output data, masked to size
- out_size_o  output  2  size of output beat
- out_ch_o  output  CH_W  source channel of output beat
- ch_empty_o  output  N_CH  per-channel FIFO empty

## Operation

- Push: ch_valid_i[c] && ch_ready_o[c] at a clk edge writes {data, size} into FIFO c.
- Eligible channel: FIFO non-empty and ch_en_i[c]=1. A disabled channel still accepts pushes but is never granted.
- Output register loads when (!out_valid_o || out_ready_i) and at least one channel is eligible. It pops exactly one beat from the granted channel.
- Fixed priority: grant the lowest-index eligible channel.
- Round-robin: search starts at rr_ptr and wraps modulo N_CH. After a grant, rr_ptr = grant+1, wrapping N_CH-1 to 0. rr_ptr is unchanged when no grant occurs.
- Switching mode_i takes effect on the next arbitration. rr_ptr is retained.
- Masking: out_data_o bits above 8/16/32 (size 0/1/2) are forced to 0. Size 2 with DATA_W<32 and size 3 pass the full width.
- Flush of channel c: FIFO c is empty after the edge. Push and flush in the same cycle: flush wins, beat dropped. Flush does not touch a beat already in the output register. A pop that would occur in the flush cycle for channel c is suppressed; no grant is made to c.
- out_valid_o, once high, holds with stable data/size/ch until out_ready_i.
- Reset mid-operation: all FIFO contents are discarded asynchronously and outputs return to reset values.

## Timing

- Reset values:
  - out_valid_o=0, out_data_o=0, out_size_o=0, out_ch_o=0
  - ch_empty_o=all 1, ch_ready_o=all 1
  - rr_ptr=0, all FIFO pointers=0
- Latency: beat pushed at edge E on an idle block gives out_valid_o=1 after edge E+1.
- Throughput: one beat per cycle with out_ready_i held high, including back-to-back beats from the same channel.
- ch_ready_o is combinational from FIFO count only; it never depends on ch_valid_i.
- Full FIFO with a pop in the same cycle: ch_ready_o stays 0 that cycle. No same-cycle push-through when full.
- Empty FIFO with a push: not eligible until the following cycle (no bypass).
- FIFO counts use CH-local pointers of $clog2(DEPTH)+1 bits. Full = count==DEPTH.

## Test plan

- Reset/basic: N_CH=4, push 0xA5A5A5A5 size 2 on ch1 at edge 0 -> out_valid_o=1 after edge 1, out_ch_o=1, data 0xA5A5A5A5. out_ready_i=1 -> out_valid_o=0 next cycle, ch_empty_o=4'b1111.
- Round-robin fairness: all four channels loaded with 3 beats, mode_i=0, out_ready_i=1 -> out_ch_o sequence 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles.
- Fixed priority and enable: mode_i=1, ch0 and ch2 loaded, ch_en_i=4'b1110 -> all ch2 beats are output, none from ch0. Set ch_en_i[0]=1 -> ch0 is granted on the next arbitration.
- Backpressure/full: DEPTH=4, out_ready_i=0, push 6 beats on ch3 -> 1 beat held in output plus 4 in FIFO, ch_ready_o[3]=0 after the 5th accept. Output stays stable and no beat is lost or duplicated once out_ready_i=1.
- Size masking: DATA_W=32, push 0xDEADBEEF with size 0, then size 1 -> out_data_o 0x000000EF, then 0x0000BEEF.
- Flush collision: ch2 holds 2 beats plus 1 in the output register. Assert ch_flush_i[2] together with a push -> after the edge ch_empty_o[2]=1 and the registered beat still completes. The pushed beat never appears.
